// File: rtl/input_port_if.sv
// Link-side and switch-side handshake bundle of one router input port.
interface input_port_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int REQUEST_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     valid_in;
  logic                     ready_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     valid_out;
  logic                     ready_out;
  logic                     routeReserveRequestValid;
  logic [REQUEST_WIDTH-1:0] routeReserveRequest;
  logic                     routeReserveStatus;
  logic                     routeRelieve;

  modport slave (
    input  data_in, valid_in, ready_out, routeReserveStatus,
    output ready_in, data_out, valid_out, routeReserveRequestValid,
           routeReserveRequest, routeRelieve
  );

  modport master (
    output data_in, valid_in, ready_out, routeReserveStatus,
    input  ready_in, data_out, valid_out, routeReserveRequestValid,
           routeReserveRequest, routeRelieve
  );
endinterface

// File: rtl/input_port_controller.sv
// Router input port: flit FIFO, XY route decode, path reserve/forward/relieve FSM.
// Optional INPUT_PORT_DROP_COUNT_EN adds a saturating count of discarded stray flits.
module input_port_controller #(
  parameter int DATA_WIDTH    = 16,
  parameter int COORD_WIDTH   = 3,
  parameter int CUR_X         = 0,
  parameter int CUR_Y         = 0,
  parameter int DEPTH         = 4,
  parameter int REQUEST_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input_port_if.slave port
`ifdef INPUT_PORT_DROP_COUNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_WIDTH-1:0]   CX          = COORD_WIDTH'(CUR_X);
  localparam logic [COORD_WIDTH-1:0]   CY          = COORD_WIDTH'(CUR_Y);
  localparam logic [REQUEST_WIDTH-1:0] ROUTE_NORTH = REQUEST_WIDTH'(0);
  localparam logic [REQUEST_WIDTH-1:0] ROUTE_SOUTH = REQUEST_WIDTH'(1);
  localparam logic [REQUEST_WIDTH-1:0] ROUTE_WEST  = REQUEST_WIDTH'(2);
  localparam logic [REQUEST_WIDTH-1:0] ROUTE_EAST  = REQUEST_WIDTH'(3);
  localparam logic [REQUEST_WIDTH-1:0] ROUTE_LOCAL = REQUEST_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQUEST, FORWARD, RELIEVE} state_t;

  function automatic logic [REQUEST_WIDTH-1:0] xy_route(input logic [2*COORD_WIDTH-1:0] coords);
    logic [COORD_WIDTH-1:0] dx;
    logic [COORD_WIDTH-1:0] dy;
    dx = coords[2*COORD_WIDTH-1:COORD_WIDTH];
    dy = coords[COORD_WIDTH-1:0];
    if (dx > CX)      return ROUTE_EAST;
    else if (dx < CX) return ROUTE_WEST;
    else if (dy > CY) return ROUTE_NORTH;
    else if (dy < CY) return ROUTE_SOUTH;
    else              return ROUTE_LOCAL;
  endfunction

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  logic                     empty, full, push, pop, discard;
  logic [DATA_WIDTH-1:0]    head_flit;
  logic [1:0]               head_type;
  state_t                   state, state_next;
  logic                     req_load, req_clear;
  logic [REQUEST_WIDTH-1:0] req_reg;
  logic [REQUEST_WIDTH-1:0] route_p0;
  logic                     vld_p0;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = port.valid_in && !full;
  assign head_flit = mem[rd_ptr[AW-1:0]];
  assign head_type = head_flit[DATA_WIDTH-1:DATA_WIDTH-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= port.data_in;
  end

  // Stage p0: route decode of a waiting head flit, registered before the request is raised
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= (state == IDLE) && !empty && head_type[0];
  end

  always_ff @(posedge clk) begin
    route_p0 <= xy_route(head_flit[2*COORD_WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    discard    = 1'b0;
    req_load   = 1'b0;
    req_clear  = 1'b0;
    case (state)
      IDLE: begin
        // Body/tail with no owning head: drop it so it cannot stall the port
        if (!empty && !head_type[0]) begin
          pop     = 1'b1;
          discard = 1'b1;
        end else if (vld_p0) begin
          req_load   = 1'b1;
          state_next = REQUEST;
        end
      end
      REQUEST: if (port.routeReserveStatus) state_next = FORWARD;
      FORWARD: begin
        if (!empty && port.ready_out) begin
          pop = 1'b1;
          if (head_type[1]) state_next = RELIEVE;
        end
      end
      RELIEVE: begin
        req_clear  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || req_clear) req_reg <= '0;
    else if (req_load)    req_reg <= route_p0;
  end

  assign port.ready_in                 = !full;
  assign port.valid_out                = (state == FORWARD) && !empty;
  assign port.data_out                 = port.valid_out ? head_flit : '0;
  assign port.routeReserveRequestValid = (state == REQUEST);
  assign port.routeReserveRequest      = req_reg;
  assign port.routeRelieve             = (state == RELIEVE);

`ifdef INPUT_PORT_DROP_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)          drop_count <= 8'd0;
    else if (discard) drop_count <= sat_inc(drop_count);
  end
`endif

endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller (CUR_X=1, CUR_Y=1, DEPTH=4) with a queue-based packet model.
module tb_input_port_controller;
  localparam int P_IDLE = 0, P_REQ = 1, P_FWD = 2, P_REL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_port_if #(.DATA_WIDTH(16), .REQUEST_WIDTH(3)) bus ();
`ifdef INPUT_PORT_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  input_port_controller #(
    .DATA_WIDTH(16), .COORD_WIDTH(3), .CUR_X(1), .CUR_Y(1), .DEPTH(4), .REQUEST_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .port(bus.slave)
`ifdef INPUT_PORT_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet queue plus the port's phase
  logic [15:0] mq[$];
  int ph = P_IDLE, age = 0, mreq = 0, mdrop = 0;

  function automatic int route(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[5:3]);
    dy = int'(f[2:0]);
    if (dx > 1) return 3;
    if (dx < 1) return 2;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  always @(posedge clk) begin : model
    logic do_push;
    if (rst) begin
      mq.delete();
      ph = P_IDLE; age = 0; mreq = 0; mdrop = 0;
    end else begin
      do_push = bus.valid_in && (mq.size() < 4);
      case (ph)
        P_IDLE: begin
          if (mq.size() == 0) age = 0;
          else if (mq[0][14] == 1'b0) begin
            void'(mq.pop_front());
            age = 0;
            if (mdrop < 255) mdrop++;
          end else if (age >= 1) begin
            ph = P_REQ; mreq = route(mq[0]); age = 0;
          end else age++;
        end
        P_REQ: if (bus.routeReserveStatus) ph = P_FWD;
        P_FWD: if (mq.size() > 0 && bus.ready_out) begin
          if (mq[0][15]) ph = P_REL;
          void'(mq.pop_front());
        end
        default: begin ph = P_IDLE; mreq = 0; end
      endcase
      if (do_push) mq.push_back(bus.data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic ev;
      logic [15:0] ed;
      ev = (ph == P_FWD) && (mq.size() > 0);
      ed = ev ? mq[0] : 16'h0000;
      check("ready_in", bus.ready_in, mq.size() < 4);
      check("valid_out", bus.valid_out, ev);
      check("data_out", bus.data_out, ed);
      check("req_valid", bus.routeReserveRequestValid, ph == P_REQ);
      check("req_code", bus.routeReserveRequest, mreq);
      check("relieve", bus.routeRelieve, ph == P_REL);
`ifdef INPUT_PORT_DROP_COUNT_EN
      check("drop_count", drop_count, mdrop);
`endif
    end
  end

  // Record DUT transfers just before the edge that performs them
  logic [15:0] fwd_log[$];
  int rel_cnt = 0;
  always @(negedge clk) begin
    #4;
    if (!rst && bus.valid_out && bus.ready_out) fwd_log.push_back(bus.data_out);
    if (!rst && bus.routeRelieve) rel_cnt++;
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f);
    int n = 0;
    bus.data_in  = f;
    bus.valid_in = 1'b1;
    while (!bus.ready_in && n < 50) begin cycle(); n++; end
    check("send_accept", bus.ready_in, 1'b1);
    cycle();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.routeReserveRequestValid && n < 40) begin cycle(); n++; end
    check("wait_req", bus.routeReserveRequestValid, 1'b1);
  endtask

  task automatic wait_relieve();
    int n = 0;
    while (!bus.routeRelieve && n < 60) begin cycle(); n++; end
    check("wait_relieve", bus.routeRelieve, 1'b1);
  endtask

  task automatic grant();
    bus.routeReserveStatus = 1'b1;
    cycle();
    bus.routeReserveStatus = 1'b0;
  endtask

  task automatic expect_flit(input string nm, input logic [15:0] e);
    logic [15:0] got;
    if (fwd_log.size() > 0) got = fwd_log.pop_front();
    else                    got = 16'hxxxx;
    check(nm, got, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in = 16'h0; bus.valid_in = 1'b0; bus.ready_out = 1'b1; bus.routeReserveStatus = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("rst ready_in", bus.ready_in, 1'b1);
    check("rst valid_out", bus.valid_out, 1'b0);
    check("rst req_valid", bus.routeReserveRequestValid, 1'b0);
    check("rst req_code", bus.routeReserveRequest, 3'd0);
    check("rst relieve", bus.routeRelieve, 1'b0);
    rst = 1'b0;

    // Three-flit packet east, grant two cycles after the request
    send(16'h4019); send(16'h0A5A); send(16'h8765);
    wait_req();
    check("t37 req", bus.routeReserveRequest, 3'd3);
    repeat (2) begin
      cycle();
      check("t37 req held", bus.routeReserveRequest, 3'd3);
    end
    grant();
    wait_relieve();
    check("t37 req at relieve", bus.routeReserveRequest, 3'd3);
    cycle();
    check("t37 relieve once", bus.routeRelieve, 1'b0);
    check("t37 req cleared", bus.routeReserveRequest, 3'd0);
    check("t37 relieve count", rel_cnt, 1);
    expect_flit("t37 flit0", 16'h4019);
    expect_flit("t37 flit1", 16'h0A5A);
    expect_flit("t37 flit2", 16'h8765);

    // Single-flit packet south
    send(16'hC008);
    wait_req();
    check("t38 req", bus.routeReserveRequest, 3'd1);
    grant();
    wait_relieve();
    check("t38 req at relieve", bus.routeReserveRequest, 3'd1);
    cycle();
    check("t38 idle req_valid", bus.routeReserveRequestValid, 1'b0);
    check("t38 idle relieve", bus.routeRelieve, 1'b0);
    check("t38 relieve count", rel_cnt, 2);
    expect_flit("t38 flit0", 16'hC008);
    check("t38 log empty", fwd_log.size(), 0);

    // Local and west destinations
    send(16'h4009);
    wait_req();
    check("t39 local", bus.routeReserveRequest, 3'd4);
    grant();
    send(16'h8001);
    wait_relieve();
    cycle();
    expect_flit("t39 local head", 16'h4009);
    expect_flit("t39 local tail", 16'h8001);
    send(16'h4002);
    wait_req();
    check("t39 west", bus.routeReserveRequest, 3'd2);
    grant();
    send(16'h8002);
    wait_relieve();
    cycle();
    expect_flit("t39 west head", 16'h4002);
    expect_flit("t39 west tail", 16'h8002);

    // Back-pressure: fill the FIFO while the switch stalls
    send(16'h4019);
    wait_req();
    bus.ready_out = 1'b0;
    grant();
    send(16'h0001); send(16'h0002); send(16'h0003);
    check("t40 full", bus.ready_in, 1'b0);
    fork
      send(16'h8004);
      begin
        repeat (3) cycle();
        check("t40 still full", bus.ready_in, 1'b0);
        check("t40 stalled valid", bus.valid_out, 1'b1);
        check("t40 stalled data", bus.data_out, 16'h4019);
        bus.ready_out = 1'b1;
      end
    join
    wait_relieve();
    cycle();
    check("t40 ready after drain", bus.ready_in, 1'b1);
    expect_flit("t40 f0", 16'h4019);
    expect_flit("t40 f1", 16'h0001);
    expect_flit("t40 f2", 16'h0002);
    expect_flit("t40 f3", 16'h0003);
    expect_flit("t40 f4", 16'h8004);

    // Stray grant and stray body while idle
    grant();
    send(16'h0123);
    repeat (4) begin
      cycle();
      check("t41 no request", bus.routeReserveRequestValid, 1'b0);
    end
    check("t41 ready_in", bus.ready_in, 1'b1);
`ifdef INPUT_PORT_DROP_COUNT_EN
    check("t41 drop_count", drop_count, 8'd1);
`endif

    // Reset in the middle of a forwarded packet
    bus.ready_out = 1'b0;
    send(16'h4019);
    wait_req();
    grant();
    cycle();
    check("t42 forwarding", bus.valid_out, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t42 valid_out", bus.valid_out, 1'b0);
    check("t42 req_valid", bus.routeReserveRequestValid, 1'b0);
    check("t42 relieve", bus.routeRelieve, 1'b0);
    check("t42 ready_in", bus.ready_in, 1'b1);
    bus.ready_out = 1'b1;
    repeat (5) cycle();
    check("t42 fifo empty", bus.routeReserveRequestValid, 1'b0);
    check("t42 no relieve", rel_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_port_controller.md
INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

Interface
REQ-001 Parameter DATA_WIDTH, 16, flit width incl. 2-bit type field [DATA_WIDTH-1:DATA_WIDTH-2].
REQ-002 Parameter COORD_WIDTH, 3, width of each mesh coordinate.
REQ-003 Parameter CUR_X, 0, this router's X coordinate.
REQ-004 Parameter CUR_Y, 0, this router's Y coordinate.
REQ-005 Parameter DEPTH, 4, input FIFO depth in flits, power of two >= 2.
REQ-006 Parameter REQUEST_WIDTH, 3, width of output-port request code.
REQ-007 clk  in  1  clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 data_in  in  DATA_WIDTH  flit from upstream link.
REQ-010 valid_in  in  1  data_in valid.
REQ-011 ready_in  out  1  FIFO can accept a flit.
REQ-012 data_out  out  DATA_WIDTH  flit toward switch mux.
REQ-013 valid_out  out  1  data_out valid.
REQ-014 ready_out  in  1  switch output accepts flit.
REQ-015 routeReserveRequestValid  out  1  path reservation request pending.
REQ-016 routeReserveRequest  out  REQUEST_WIDTH  requested output: 0 North, 1 South, 2 West, 3 East, 4 Local.
REQ-017 routeReserveStatus  in  1  one-cycle grant pulse from switch controller.
REQ-018 routeRelieve  out  1  one-cycle path release pulse.

Function
REQ-019 Flit types SHALL be: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
REQ-020 Head flit destination SHALL be dest_x = data[2*COORD_WIDTH-1:COORD_WIDTH], dest_y = data[COORD_WIDTH-1:0].
REQ-021 Route SHALL be XY: dest_x>CUR_X East; dest_x<CUR_X West; else dest_y>CUR_Y North; dest_y<CUR_Y South; else Local.
REQ-022 FIFO push on valid_in & ready_in; ready_in = ~full (no full-bypass); pop only when non-empty; simultaneous push/pop keeps occupancy.
REQ-023 FSM states SHALL be IDLE, REQUEST, FORWARD, RELIEVE.
REQ-024 IDLE: FIFO head is head or head+tail -> latch route into routeReserveRequest, go REQUEST; no pop.
REQ-025 IDLE: FIFO head is body or tail -> pop (discard) it, stay IDLE, no request issued.
REQ-026 REQUEST: routeReserveRequestValid=1, routeReserveRequest held; routeReserveStatus=1 -> FORWARD; otherwise stay indefinitely.
REQ-027 FORWARD: valid_out = ~empty, data_out = FIFO head; pop on valid_out & ready_out; valid_out=0 and data_out=0 outside FORWARD.
REQ-028 FORWARD: popped flit of type tail or head+tail -> RELIEVE; flits behind it are not forwarded this packet.
REQ-029 RELIEVE: routeRelieve=1 for exactly one cycle, routeReserveRequest still held, then IDLE.
REQ-030 routeReserveRequest SHALL stay stable from REQUEST entry through RELIEVE inclusive; 0 in IDLE.
REQ-031 Latency: head flit pushed at edge T -> routeReserveRequestValid=1 from edge T+2.
REQ-032 routeReserveStatus outside REQUEST SHALL be ignored.

Reset
REQ-033 rst SHALL empty FIFO, set IDLE, drive ready_in=1 (after reset), all other outputs 0.
REQ-034 rst mid-packet SHALL abandon it without routeRelieve; switch controller is reset by same rst.

Configuration
REQ-035 With INPUT_PORT_DROP_COUNT_EN defined, output drop_count [7:0] SHALL count discarded flits (REQ-025), saturating at 255, reset 0.
REQ-036 Without INPUT_PORT_DROP_COUNT_EN, port drop_count and counter SHALL not exist; discard behaviour unchanged.

Verification (CUR_X=1, CUR_Y=1, COORD_WIDTH=3, DATA_WIDTH=16)
REQ-037 Head dest (3,1), body, tail; grant 2 cycles after request -> request=3 held; 3 flits out in order; routeRelieve one pulse after tail, request still 3.
REQ-038 Single head+tail dest (1,0) -> request=1; one flit out; relieve next cycle; back to IDLE.
REQ-039 Head dest (1,1) -> request=4; head dest (0,2) -> request=2.
REQ-040 ready_out=0 in FORWARD, push 4 flits -> ready_in=0 after 4th, 5th held upstream; ready_out=1 -> drains in order, ready_in=1.
REQ-041 Body flit in IDLE -> discarded, routeReserveRequestValid stays 0; with macro drop_count=1.
REQ-042 rst asserted in FORWARD -> next cycle valid_out=0, routeReserveRequestValid=0, routeRelieve=0, FIFO empty.
